// File: rtl/log_lut_unit.sv
// Iterative natural log: unsigned Q30.34 operand in, signed Q6.34 ln(x) out, one operation in flight.
// Latency: result valid ITERATIONS+2 cycles after the accept cycle (2 cycles when x==0), data independent otherwise.
// Backpressure: o_ready only in IDLE; the result is held stable in DONE until i_ready. Macro LOG_LUT_ROUND_EN selects rounded output.
module log_lut_unit #(
    parameter int ITERATIONS = 34,  // legal 8..34
    parameter int GUARD_BITS = 4    // legal 1..24
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [63:0] i_value,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [40:0] o_ln,
    output logic        o_err
);

    localparam int OUT_FB = 34;                   // output fraction bits
    localparam int FB     = OUT_FB + GUARD_BITS;  // internal fraction bits
    localparam int MW     = FB + 1;               // mantissa width, Q1.FB in [1,2)
    localparam int YW     = 41 + GUARD_BITS;      // log accumulator width, signed
    localparam int PREC   = 62;                   // working precision of the table generator

    // -ln(1 - 2^-i) at FB fraction bits, from the series sum over n of 2^-(i*n)/n.
    // Evaluated at elaboration only; c_1 doubles as ln2.
    function automatic logic [YW-1:0] f_c(input int i);
        logic [63:0] s;
        s = '0;
        if (i >= 1) begin
            for (int n = 1; n <= PREC; n++) begin
                if (i * n <= PREC) begin
                    s = s + ((64'd1 << (PREC - i * n)) / 64'(n));
                end
            end
        end
        s = s + (64'd1 << (PREC - FB - 1));
        return YW'(s >> (PREC - FB));
    endfunction

    localparam logic signed [YW-1:0] LN2_S  = f_c(1);
    localparam logic        [40:0]   LN_MIN = {1'b1, 40'd0};
`ifdef LOG_LUT_ROUND_EN
    localparam logic signed [YW-1:0] RND    = YW'(1) <<< (GUARD_BITS - 1);
`endif

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ITER, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [63:0]           r_x;
    logic [MW-1:0]         r_m;
    logic signed [YW-1:0]  r_y;
    logic [5:0]            r_i;
    logic [40:0]           r_ln;
    logic                  r_err;

    logic [5:0]            w_p;
    logic signed [7:0]     w_k;
    logic [MW-1:0]         w_m_norm;
    logic signed [YW-1:0]  w_ky;
    logic [MW-1:0]         w_t;
    logic [MW-1:0]         w_m_next;
    logic signed [YW-1:0]  w_y_next;
    logic [40:0]           w_ln_next;
    logic                  w_last;
    logic [YW-1:0]         w_ctab [0:63];

    // Constant table, indexed directly by the step counter
    for (genvar g = 0; g < 64; g++) begin : g_ctab
        localparam logic [YW-1:0] C = f_c(g);
        assign w_ctab[g] = C;
    end

    assign w_last = (r_i == 6'(ITERATIONS));

    // Normalise: MSB position, exponent k = p-34, mantissa into [1,2), y0 = k*ln2
    always_comb begin
        w_p = 6'd0;
        for (int b = 0; b < 64; b++) begin
            if (r_x[b]) w_p = 6'(b);
        end
        w_k = $signed({2'b00, w_p}) - 8'sd34;
        if (w_p >= 6'(FB)) begin
            w_m_norm = MW'(r_x >> (w_p - 6'(FB)));
        end else begin
            w_m_norm = MW'(r_x << (6'(FB) - w_p));
        end
        w_ky = YW'(w_k) * LN2_S;
    end

    // One shift-add step: take the factor (1-2^-i) only if m stays >= 1
    always_comb begin
        w_t      = r_m - (r_m >> r_i);
        w_m_next = r_m;
        w_y_next = r_y;
        if (w_t[FB]) begin
            w_m_next = w_t;
            w_y_next = r_y + $signed(w_ctab[r_i]);
        end
`ifdef LOG_LUT_ROUND_EN
        w_ln_next = 41'((w_y_next + RND) >>> GUARD_BITS);
`else
        w_ln_next = 41'(w_y_next >>> GUARD_BITS);
`endif
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_valid) w_state_nxt = S_NORM;
            S_NORM:  w_state_nxt = (r_x == 64'd0) ? S_DONE : S_ITER;
            S_ITER:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (i_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (r_state)
            S_IDLE:  o_ready = 1'b1;
            S_DONE:  o_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: capture, normalise, iterate, load result on DONE entry
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x   <= '0;
            r_m   <= '0;
            r_y   <= '0;
            r_i   <= '0;
            r_ln  <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) r_x <= i_value;
                end
                S_NORM: begin
                    r_m <= w_m_norm;
                    r_y <= w_ky;
                    r_i <= 6'd1;
                    if (r_x == 64'd0) begin
                        r_ln  <= LN_MIN;
                        r_err <= 1'b1;
                    end
                end
                S_ITER: begin
                    r_m <= w_m_next;
                    r_y <= w_y_next;
                    r_i <= r_i + 6'd1;
                    if (w_last) begin
                        r_ln  <= w_ln_next;
                        r_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ln  = r_ln;
    assign o_err = r_err;

endmodule

// File: tb/tb_log_lut_unit.sv
// Directed bench for log_lut_unit: hand-computed ln values, latency, hold/backpressure and reset abort.
// Expected Q6.34 constants derived from the hex expansions of ln2, e and ln3.
// Every comparison runs through chk(); one summary line at the end.
module tb_log_lut_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] i_value;
    logic        o_valid;
    logic        i_ready;
    logic [40:0] o_ln;
    logic        o_err;

    int n_vec = 0;
    int n_bad = 0;

    localparam longint LN2_Q34 = 64'sd11908177887;    // ln2 * 2^34
    localparam longint LN3_Q34 = 64'sd18874015403;    // ln3 * 2^34
    localparam longint ONE_Q34 = 64'sd17179869184;    // 2^34
    localparam longint LN_LO   = 64'sd404878048167;   // 34*ln2 * 2^34
    localparam longint LN_HI   = 64'sd345337158731;   // 29*ln2 * 2^34
    localparam longint LN_MIN  = 64'sd1099511627776;  // 2^40
    localparam int     LAT     = 36;

    always #5 i_clk = ~i_clk;

    log_lut_unit dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_value (i_value),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_ln    (o_ln),
        .o_err   (o_err)
    );

    task automatic chk(input string tag, input longint obs, input longint exp, input longint tol);
        longint d;
        n_vec++;
        d = obs - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic longint ln_s();
        return longint'($signed(o_ln));
    endfunction

    // Offer v, check latency/result; optionally stall the consumer and drive junk while busy
    task automatic run_op(input string tag, input logic [63:0] v, input longint exp_ln,
                          input longint tol, input int exp_err, input int exp_lat,
                          input int hold, input bit junk);
        int lat;
        int g;
        g = 0;
        while (o_ready !== 1'b1 && g < 100) begin
            @(negedge i_clk);
            g++;
        end
        i_value = v;
        i_valid = 1'b1;
        i_ready = (hold == 0);
        lat = 0;
        do begin
            @(negedge i_clk);
            lat++;
            if (lat == 1) begin
                chk({tag, "_busy_rdy"}, longint'(o_ready), 0, 0);
                if (junk) i_value = 64'h0;
                else      i_valid = 1'b0;
            end
        end while (o_valid !== 1'b1 && lat < 200);
        chk({tag, "_lat"}, longint'(lat), longint'(exp_lat), 0);
        chk({tag, "_ln"}, ln_s(), exp_ln, tol);
        chk({tag, "_err"}, longint'(o_err), longint'(exp_err), 0);
        for (int c = 0; c < hold; c++) begin
            @(negedge i_clk);
            chk({tag, "_hold_vld"}, longint'(o_valid), 1, 0);
            chk({tag, "_hold_rdy"}, longint'(o_ready), 0, 0);
            chk({tag, "_hold_ln"}, ln_s(), exp_ln, tol);
            chk({tag, "_hold_err"}, longint'(o_err), longint'(exp_err), 0);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        chk({tag, "_post_vld"}, longint'(o_valid), 0, 0);
        chk({tag, "_post_rdy"}, longint'(o_ready), 1, 0);
        i_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int seen;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_value = '0;
        repeat (3) @(negedge i_clk);
        chk("rst_rdy", longint'(o_ready), 1, 0);
        chk("rst_vld", longint'(o_valid), 0, 0);
        chk("rst_ln",  ln_s(), 0, 0);
        chk("rst_err", longint'(o_err), 0, 0);
        i_rst = 1'b0;
        @(negedge i_clk);

        run_op("one",  64'h0000_0004_0000_0000, 0,        0, 0, LAT, 0, 1'b0);
        run_op("two",  64'h0000_0008_0000_0000, LN2_Q34,  4, 0, LAT, 0, 1'b0);
        run_op("half", 64'h0000_0002_0000_0000, -LN2_Q34, 4, 0, LAT, 0, 1'b0);
        run_op("e",    64'h0000_000A_DF85_458A, ONE_Q34,  4, 0, LAT, 0, 1'b0);
        run_op("min",  64'h0000_0000_0000_0001, -LN_LO,   4, 0, LAT, 0, 1'b0);
        run_op("max",  64'h8000_0000_0000_0000, LN_HI,    4, 0, LAT, 0, 1'b0);
        run_op("zero", 64'h0000_0000_0000_0000, -LN_MIN,  0, 1, 2,   0, 1'b0);
        // Stalled consumer with junk (x=0) offered throughout the operation
        run_op("hold", 64'h0000_000A_DF85_458A, ONE_Q34,  4, 0, LAT, 10, 1'b1);

        // Abort mid-iteration with a one-cycle reset
        g = 0;
        while (o_ready !== 1'b1 && g < 100) begin
            @(negedge i_clk);
            g++;
        end
        i_value = 64'h0000_0008_0000_0000;
        i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (10) @(negedge i_clk);
        chk("abort_busy", longint'(o_ready), 0, 0);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("abort_rdy", longint'(o_ready), 1, 0);
        chk("abort_vld", longint'(o_valid), 0, 0);
        seen = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_valid === 1'b1) seen++;
        end
        chk("abort_no_result", longint'(seen), 0, 0);
        run_op("three", 64'h0000_000C_0000_0000, LN3_Q34, 4, 0, LAT, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
